// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and tick constants for the generation controller
package life_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT, S_DONE} life_ctrl_state_t;
  localparam logic [2:0] TICK_LOAD = 3'd0;
  localparam logic [2:0] TICK_COMMIT = 3'd7;
endpackage

// File: rtl/life_generation_ctrl_if.sv
// life_generation_ctrl_if: control inputs and phase/status outputs of the generation controller
interface life_generation_ctrl_if #(
  parameter int GEN_W = 16,
  parameter int PAUSE_W = 8
);
  logic run;
  logic step;
  logic clear;
  logic [PAUSE_W-1:0] pause_cycles;
  logic [GEN_W-1:0] gen_limit;
  logic phase_load;
  logic phase_compute;
  logic phase_commit;
  logic busy;
  logic done;
  logic [GEN_W-1:0] generation;
  modport master (
    output run, step, clear, pause_cycles, gen_limit,
    input phase_load, phase_compute, phase_commit, busy, done, generation
  );
  modport slave (
    input run, step, clear, pause_cycles, gen_limit,
    output phase_load, phase_compute, phase_commit, busy, done, generation
  );
endinterface

// File: rtl/timer_8tick.sv
// timer_8tick: free-running 3-bit tick counter, held at 0 while rst is high
module timer_8tick (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] tick_out
);
  logic [2:0] tick_q, tick_d;
  // advance one tick per cycle, wrapping 7 -> 0
  always_comb tick_d = tick_q + 3'd1;
  // tick register
  always_ff @(posedge clk) tick_q <= rst ? 3'd0 : tick_d;
  assign tick_out = tick_q;
endmodule

// File: rtl/life_generation_ctrl.sv
// life_generation_ctrl: sequences load/compute/commit frames, pauses, counts and limits generations
module life_generation_ctrl
  import life_pkg::*;
#(
  parameter int GEN_W = 16,
  parameter int PAUSE_W = 8
) (
  input logic clk,
  input logic rst,
  life_generation_ctrl_if.slave bus
);
  life_ctrl_state_t state_q, state_d;
  logic [GEN_W-1:0] generation_q, generation_d, gen_inc;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic done_q, done_d;
  logic [2:0] tick;
  logic timer_rst, in_gen;
  assign in_gen = state_q == S_GEN;
  assign timer_rst = rst | bus.clear | !in_gen;
  assign gen_inc = generation_q + GEN_W'(1);
  timer_8tick u_timer (.clk(clk), .rst(timer_rst), .tick_out(tick));
  // next state, counters and done flag; clear overrides everything
  always_comb begin
    state_d = state_q;
    generation_d = generation_q;
    pause_d = pause_q;
    done_d = done_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      generation_d = '0;
      done_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = (bus.run | bus.step) ? S_GEN : S_IDLE;
        S_GEN: if (tick == TICK_COMMIT) begin
          generation_d = gen_inc;
          pause_d = bus.pause_cycles;
          done_d = bus.gen_limit != '0 && gen_inc == bus.gen_limit;
          state_d = done_d ? S_DONE :
                    !bus.run ? S_IDLE :
                    bus.pause_cycles == '0 ? S_GEN : S_WAIT;
        end
        S_WAIT: begin
          pause_d = pause_q - PAUSE_W'(1);
          state_d = !bus.run ? S_IDLE : pause_q == PAUSE_W'(1) ? S_GEN : S_WAIT;
        end
        S_DONE: state_d = S_DONE;
      endcase
    end
  end
  // state, counters and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      generation_q <= '0;
      pause_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      generation_q <= generation_d;
      pause_q <= pause_d;
      done_q <= done_d;
    end
  end
  assign bus.phase_load = in_gen && tick == TICK_LOAD;
  assign bus.phase_compute = in_gen && tick != TICK_LOAD && tick != TICK_COMMIT;
  assign bus.phase_commit = in_gen && tick == TICK_COMMIT;
  assign bus.busy = in_gen || state_q == S_WAIT;
  assign bus.done = done_q;
  assign bus.generation = generation_q;
endmodule

// File: tb/tb_life_generation_ctrl.sv
// tb_life_generation_ctrl: directed checks of framing, pause, limit, clear, wrap and reset
module tb_life_generation_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  life_generation_ctrl_if #(.GEN_W(16), .PAUSE_W(8)) b1 ();
  life_generation_ctrl_if #(.GEN_W(4), .PAUSE_W(8)) b2 ();
  life_generation_ctrl #(.GEN_W(16), .PAUSE_W(8)) dut (.clk(clk), .rst(rst), .bus(b1));
  life_generation_ctrl #(.GEN_W(4), .PAUSE_W(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] ph1();
    return {b1.phase_load, b1.phase_compute, b1.phase_commit, b1.busy};
  endfunction
  function automatic logic [3:0] ph2();
    return {b2.phase_load, b2.phase_compute, b2.phase_commit, b2.busy};
  endfunction
  function automatic logic [3:0] exp_ph(input int t);
    return t == 0 ? 4'b1001 : t == 7 ? 4'b0011 : 4'b0101;
  endfunction
  initial begin
    b1.run = 0; b1.step = 0; b1.clear = 0; b1.pause_cycles = 0; b1.gen_limit = 0;
    b2.run = 0; b2.step = 0; b2.clear = 0; b2.pause_cycles = 0; b2.gen_limit = 0;
    cyc(); cyc();
    chk("rst_phases", 32'(ph1()), 32'h0);
    chk("rst_done", 32'(b1.done), 32'h0);
    chk("rst_gen", 32'(b1.generation), 32'h0);
    rst = 0;
    cyc();
    chk("idle_phases", 32'(ph1()), 32'h0);
    // 1: single step
    b1.step = 1; cyc(); b1.step = 0;
    chk("t1_load", 32'(ph1()), 32'(exp_ph(0)));
    for (int t = 1; t < 8; t++) begin
      cyc();
      chk($sformatf("t1_tick%0d", t), 32'(ph1()), 32'(exp_ph(t)));
    end
    chk("t1_gen_pre", 32'(b1.generation), 32'h0);
    cyc();
    chk("t1_idle", 32'(ph1()), 32'h0);
    chk("t1_gen", 32'(b1.generation), 32'h1);
    // 2: back-to-back generations
    b1.clear = 1; cyc(); b1.clear = 0;
    chk("t2_cleared", 32'(b1.generation), 32'h0);
    b1.run = 1; cyc();
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("t2_c%0d", k), 32'(ph1()), 32'(exp_ph(k % 8)));
      if (k == 20) b1.run = 0;
      cyc();
    end
    chk("t2_idle", 32'(ph1()), 32'h0);
    chk("t2_gen", 32'(b1.generation), 32'h3);
    // 3: pause between generations
    b1.clear = 1; cyc(); b1.clear = 0;
    b1.pause_cycles = 5; b1.run = 1; cyc();
    chk("t3_load", 32'(ph1()), 32'(exp_ph(0)));
    repeat (7) cyc();
    chk("t3_commit", 32'(ph1()), 32'(exp_ph(7)));
    for (int w = 0; w < 5; w++) begin
      cyc();
      chk($sformatf("t3_wait%0d", w), 32'(ph1()), 32'b0001);
    end
    cyc();
    chk("t3_load2", 32'(ph1()), 32'(exp_ph(0)));
    repeat (7) cyc();
    chk("t3_commit2", 32'(ph1()), 32'(exp_ph(7)));
    cyc();
    chk("t3_wait_again", 32'(ph1()), 32'b0001);
    b1.run = 0; cyc();
    chk("t3_drop_idle", 32'(ph1()), 32'h0);
    chk("t3_gen", 32'(b1.generation), 32'h2);
    cyc();
    chk("t3_stay_idle", 32'(ph1()), 32'h0);
    // 4: generation limit
    b1.clear = 1; cyc(); b1.clear = 0;
    b1.pause_cycles = 0; b1.gen_limit = 2; b1.run = 1; cyc();
    chk("t4_load", 32'(ph1()), 32'(exp_ph(0)));
    repeat (15) cyc();
    chk("t4_commit2", 32'(ph1()), 32'(exp_ph(7)));
    cyc();
    chk("t4_done", 32'(b1.done), 32'h1);
    chk("t4_phases", 32'(ph1()), 32'h0);
    chk("t4_gen", 32'(b1.generation), 32'h2);
    b1.step = 1; cyc(); b1.step = 0; cyc();
    chk("t4_ignore_done", 32'(b1.done), 32'h1);
    chk("t4_ignore_ph", 32'(ph1()), 32'h0);
    b1.clear = 1; b1.run = 0; cyc(); b1.clear = 0;
    chk("t4_clr_done", 32'(b1.done), 32'h0);
    chk("t4_clr_gen", 32'(b1.generation), 32'h0);
    b1.gen_limit = 0;
    // 5: clear mid-frame
    b1.run = 1; cyc();
    chk("t5_load1", 32'(ph1()), 32'(exp_ph(0)));
    repeat (8) cyc();
    chk("t5_load2", 32'(ph1()), 32'(exp_ph(0)));
    chk("t5_gen1", 32'(b1.generation), 32'h1);
    repeat (4) cyc();
    chk("t5_tick4", 32'(ph1()), 32'(exp_ph(4)));
    b1.clear = 1; b1.run = 0; cyc(); b1.clear = 0;
    chk("t5_abort_ph", 32'(ph1()), 32'h0);
    chk("t5_abort_gen", 32'(b1.generation), 32'h0);
    b1.run = 1; cyc(); b1.run = 0;
    chk("t5_restart_load", 32'(ph1()), 32'(exp_ph(0)));
    repeat (7) cyc();
    chk("t5_restart_commit", 32'(ph1()), 32'(exp_ph(7)));
    cyc();
    chk("t5_gen_after", 32'(b1.generation), 32'h1);
    // 6: 4-bit counter wrap, then reset mid-frame
    b2.run = 1; cyc();
    chk("t6_load", 32'(ph2()), 32'(exp_ph(0)));
    repeat (120) cyc();
    chk("t6_gen15", 32'(b2.generation), 32'hF);
    repeat (8) cyc();
    chk("t6_gen0", 32'(b2.generation), 32'h0);
    repeat (8) cyc();
    chk("t6_gen1", 32'(b2.generation), 32'h1);
    repeat (3) cyc();
    chk("t6_tick3", 32'(ph2()), 32'(exp_ph(3)));
    rst = 1; cyc();
    chk("t6_rst_ph", 32'(ph2()), 32'h0);
    chk("t6_rst_gen", 32'(b2.generation), 32'h0);
    chk("t6_rst_done", 32'(b2.done), 32'h0);
    b2.run = 0; rst = 0; cyc();
    chk("t6_idle", 32'(ph2()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
